// File: rtl/rs_pulse_gen.sv
// rs_pulse_gen: turns two raw, bouncy push-buttons into clean, mutually exclusive,
// fixed-width set/reset pulses for a downstream s/r latch.
// Each button path: 2-flop synchroniser -> debouncer -> rising-edge event.
// A three-state FSM (idle / set pulse / reset pulse) arbitrates the events. It holds
// at most one pending event for the channel that is not pulsing.
// Optional build macro RS_EVENT_CNT_EN adds saturating event counters
// (set_cnt/rst_cnt, CNT_W bits wide). Without it, those ports and that logic are absent.
module rs_pulse_gen #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_W    = 2
`ifdef RS_EVENT_CNT_EN
  ,
  parameter int unsigned CNT_W      = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_s,
  input  logic             btn_r,
  output logic             s,
  output logic             r,
  output logic             busy
`ifdef RS_EVENT_CNT_EN
  ,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt
`endif
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PulW = $clog2(PULSE_W + 1);
  // The level flips on the edge where the counter would reach DEB_CYCLES.
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [PulW-1:0] PulLast = PulW'(PULSE_W - 1);

  typedef enum logic [1:0] {StIdle, StSPulse, StRPulse} state_e;

  // Channel index 0 = set button, 1 = reset button.
  logic [1:0]      btn;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d, deb_prev_q;
  logic [DebW-1:0] cnt_q [2];
  logic [DebW-1:0] cnt_d [2];
  logic            ev_s, ev_r;

  state_e          state_q, state_d;
  logic [PulW-1:0] pcnt_q, pcnt_d;
  logic            pend_s_q, pend_s_d;
  logic            pend_r_q, pend_r_d;
  logic            s_q, s_d;
  logic            r_q, r_d;

  assign btn = {btn_r, btn_s};

  // Synchroniser, debounce and edge-detect registers for both channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  // Debounce: count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  // Only rising debounced edges are events; releases are ignored.
  assign ev_s = deb_q[0] & ~deb_prev_q[0];
  assign ev_r = deb_q[1] & ~deb_prev_q[1];

  // FSM state register together with pulse counter, pending flags and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pcnt_q   <= '0;
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      pend_s_q <= pend_s_d;
      pend_r_q <= pend_r_d;
      s_q      <= s_d;
      r_q      <= r_d;
    end
  end

  // Next-state: reset wins over set; the loser of a collision is remembered as pending.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    pend_s_d = pend_s_q;
    pend_r_d = pend_r_q;
    case (state_q)
      StIdle: begin
        pcnt_d = '0;
        if (ev_r) begin
          state_d  = StRPulse;
          pend_r_d = 1'b0;
          if (ev_s) pend_s_d = 1'b1;
        end else if (ev_s) begin
          state_d  = StSPulse;
          pend_s_d = 1'b0;
        end else if (pend_r_q) begin
          state_d  = StRPulse;
          pend_r_d = 1'b0;
        end else if (pend_s_q) begin
          state_d  = StSPulse;
          pend_s_d = 1'b0;
        end
      end
      StSPulse: begin
        // A repeat set event is dropped; a reset event waits for the next idle cycle.
        if (ev_r) pend_r_d = 1'b1;
        if (pcnt_q == PulLast) begin
          state_d = StIdle;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PulW'(1);
        end
      end
      StRPulse: begin
        if (ev_s) pend_s_d = 1'b1;
        if (pcnt_q == PulLast) begin
          state_d = StIdle;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PulW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        pcnt_d  = '0;
      end
    endcase
  end

  // Outputs: s/r are registered copies of the next state; busy covers queued work too.
  always_comb begin
    s_d  = (state_d == StSPulse);
    r_d  = (state_d == StRPulse);
    busy = (state_q != StIdle) | pend_s_q | pend_r_q;
  end

  assign s = s_q;
  assign r = r_q;

`ifdef RS_EVENT_CNT_EN
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  // Count pulse-state entries, saturating at all ones.
  always_comb begin
    set_cnt_d = set_cnt_q;
    rst_cnt_d = rst_cnt_q;
    if ((state_d == StSPulse) && (state_q != StSPulse) && (set_cnt_q != {CNT_W{1'b1}})) begin
      set_cnt_d = set_cnt_q + CNT_W'(1);
    end
    if ((state_d == StRPulse) && (state_q != StRPulse) && (rst_cnt_q != {CNT_W{1'b1}})) begin
      rst_cnt_d = rst_cnt_q + CNT_W'(1);
    end
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_cnt_q <= '0;
      rst_cnt_q <= '0;
    end else begin
      set_cnt_q <= set_cnt_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign set_cnt = set_cnt_q;
  assign rst_cnt = rst_cnt_q;
`endif

endmodule
